// File: rtl/lsu_cache_req_pkg.sv
// lsu_cache_req_pkg: shared widths, access-size codes, byte-lane one-hots and FSM states
package lsu_cache_req_pkg;
  localparam int XLEN = 64;
  localparam int RD_W = 5;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} size_e;
  localparam logic [7:0] DWHB_B = 8'h01;
  localparam logic [7:0] DWHB_H = 8'h02;
  localparam logic [7:0] DWHB_W = 8'h04;
  localparam logic [7:0] DWHB_D = 8'h08;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  function automatic logic [7:0] dwhb(size_e s);
    return s == SZ_B ? DWHB_B : s == SZ_H ? DWHB_H : s == SZ_W ? DWHB_W : DWHB_D;
  endfunction
  function automatic logic misaligned(size_e s, logic [2:0] a);
    return s == SZ_H ? a[0] : s == SZ_W ? |a[1:0] : s == SZ_D ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the doubleword down to the accessed field and sign/zero-extends it
module lsu_load_align
  import lsu_cache_req_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      off,
  input  size_e           size,
  input  logic            uns,
  output logic [XLEN-1:0] res
);
  logic [XLEN-1:0] raw;
  assign raw = data >> {off, 3'b000};
  assign res = size == SZ_B ? {{56{~uns & raw[7]}}, raw[7:0]}
             : size == SZ_H ? {{48{~uns & raw[15]}}, raw[15:0]}
             : size == SZ_W ? {{32{~uns & raw[31]}}, raw[31:0]}
             : raw;
endmodule

// File: rtl/lsu_cache_req.sv
// lsu_cache_req: memory-stage load/store unit driving the data-cache handshake and holding results for WB
module lsu_cache_req
  import lsu_cache_req_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [1:0]      ex_size,
  input  logic            ex_unsigned,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [RD_W-1:0] ex_rd,
  output logic            cache_valid,
  output logic            op_read,
  output logic [XLEN-1:0] read_address,
  output logic [XLEN-1:0] write_address,
  output logic [XLEN-1:0] write_data,
  output logic [7:0]      write_shifter,
  output logic [7:0]      write_DWHB,
  input  logic            cache_ready,
  input  logic            cache_out_valid,
  input  logic [XLEN-1:0] cache_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_wen,
  output logic            wb_misalign
);
  state_e state, state_nx;
  size_e size;
  logic uns, accept, mem_op, mis;
  logic [XLEN-1:0] addr, wdata, ld_data;
  logic [7:0] dwhb_r;
  assign accept = ex_valid && state == IDLE;
  assign mem_op = ex_is_load || ex_is_store;
  assign mis = mem_op && misaligned(size_e'(ex_size), ex_addr[2:0]);
  assign ex_ready = state == IDLE;
  assign cache_valid = state == REQ;
  assign wb_valid = state == RESP;
  assign read_address = addr;
  assign write_address = addr;
  assign write_data = wdata;
  assign write_shifter = {addr[2:0], 3'b000};
  assign write_DWHB = dwhb_r;
  lsu_load_align u_align (.data(cache_data), .off(addr[2:0]), .size(size), .uns(uns), .res(ld_data));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && ex_valid) state_nx = mem_op && !mis ? REQ : RESP;
    if (state == REQ && cache_ready) state_nx = WAIT;
    if (state == WAIT && cache_out_valid) state_nx = RESP;
    if (state == RESP && wb_ready) state_nx = IDLE;
  end
  // Misaligned and pass-through results are final at accept; memory ops overwrite on response.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      op_read <= 1'b0;
      size <= SZ_B;
      uns <= 1'b0;
      addr <= '0;
      wdata <= '0;
      dwhb_r <= '0;
      wb_rd <= '0;
      wb_data <= '0;
      wb_wen <= 1'b0;
      wb_misalign <= 1'b0;
    end else if (accept) begin
      op_read <= ex_is_load;
      size <= size_e'(ex_size);
      uns <= ex_unsigned;
      addr <= ex_addr;
      wdata <= ex_wdata;
      dwhb_r <= dwhb(size_e'(ex_size));
      wb_rd <= ex_rd;
      wb_data <= mem_op ? '0 : ex_wdata;
      wb_wen <= !mem_op;
      wb_misalign <= mis;
    end else if (state == WAIT && cache_out_valid) begin
      wb_data <= op_read ? ld_data : '0;
      wb_wen <= op_read;
    end
endmodule

// File: tb/tb_lsu_cache_req.sv
// tb_lsu_cache_req: directed and randomized ops checked against a byte-level load/store reference model
module tb_lsu_cache_req;
  logic clk = 0, reset_n = 0;
  logic ex_valid = 0, ex_is_load = 0, ex_is_store = 0, ex_unsigned = 0, ex_ready;
  logic [1:0] ex_size = 0;
  logic [63:0] ex_addr = 0, ex_wdata = 0, cache_data = 0;
  logic [63:0] read_address, write_address, write_data, wb_data;
  logic [4:0] ex_rd = 0, wb_rd;
  logic cache_ready = 0, cache_out_valid = 0, wb_ready = 0;
  logic cache_valid, op_read, wb_valid, wb_wen, wb_misalign;
  logic [7:0] write_shifter, write_DWHB;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  lsu_cache_req dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .cache_valid(cache_valid), .op_read(op_read), .read_address(read_address),
    .write_address(write_address), .write_data(write_data), .write_shifter(write_shifter),
    .write_DWHB(write_DWHB), .cache_ready(cache_ready), .cache_out_valid(cache_out_valid),
    .cache_data(cache_data), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_misalign(wb_misalign)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [2:0] off,
                                           input logic [1:0] sz, input bit uns);
    int n;
    logic [63:0] v, m;
    n = 8 << sz;
    m = (n == 64) ? '1 : ((64'd1 << n) - 1);
    v = (d >> (8 * off)) & m;
    if (!uns && v[n-1]) v = v | ~m;
    return v;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_ex_ready"}, ex_ready, 1);
    chk({tag, "_cache_valid"}, cache_valid, 0);
    chk({tag, "_op_read"}, op_read, 0);
    chk({tag, "_read_address"}, read_address, 0);
    chk({tag, "_write_address"}, write_address, 0);
    chk({tag, "_write_data"}, write_data, 0);
    chk({tag, "_write_shifter"}, write_shifter, 0);
    chk({tag, "_write_DWHB"}, write_DWHB, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_wb_rd"}, wb_rd, 0);
    chk({tag, "_wb_wen"}, wb_wen, 0);
    chk({tag, "_wb_misalign"}, wb_misalign, 0);
  endtask

  // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
  task automatic op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                    input logic [63:0] a, input logic [63:0] wd, input logic [63:0] dat,
                    input logic [4:0] rd, input int rdly, input int wdly, input int odly);
    bit mem, mis, wen;
    logic [63:0] ed;
    mem = ld | st;
    mis = mem && (a % (64'd1 << sz)) != 0;
    wen = (ld || !mem) && !mis;
    ed = !mem ? wd : (ld && !mis) ? ref_load(dat, a[2:0], sz, uns) : 64'd0;
    chk("ex_ready_idle", ex_ready, 1);
    ex_valid = 1; ex_is_load = ld; ex_is_store = st; ex_size = sz; ex_unsigned = uns;
    ex_addr = a; ex_wdata = wd; ex_rd = rd;
    @(negedge clk);
    ex_valid = 0; ex_addr = {$urandom, $urandom}; ex_wdata = {$urandom, $urandom};
    ex_size = 2'($urandom); ex_rd = 5'($urandom);
    chk("ex_ready_busy", ex_ready, 0);
    if (mem && !mis) begin
      for (int i = 0; i <= rdly; i++) begin
        chk("cache_valid", cache_valid, 1);
        chk("op_read", op_read, ld);
        chk("read_address", read_address, a);
        chk("write_address", write_address, a);
        chk("write_shifter", write_shifter, 64'(a[2:0]) * 8);
        chk("write_DWHB", write_DWHB, 64'd1 << sz);
        chk("write_data", write_data, wd);
        if (i == rdly) cache_ready = 1;
        @(negedge clk);
      end
      cache_ready = 0;
      for (int i = 0; i <= odly; i++) begin
        chk("cache_valid_wait", cache_valid, 0);
        chk("wb_valid_wait", wb_valid, 0);
        if (i == odly) begin
          cache_out_valid = 1;
          cache_data = dat;
        end
        @(negedge clk);
      end
      cache_out_valid = 0;
      cache_data = {$urandom, $urandom};
    end
    for (int i = 0; i <= wdly; i++) begin
      chk("wb_valid", wb_valid, 1);
      chk("wb_data", wb_data, ed);
      chk("wb_rd", wb_rd, rd);
      chk("wb_wen", wb_wen, wen);
      chk("wb_misalign", wb_misalign, mis);
      chk("cache_valid_resp", cache_valid, 0);
      chk("ex_ready_resp", ex_ready, 0);
      if (i == wdly) wb_ready = 1;
      @(negedge clk);
    end
    wb_ready = 0;
    chk("wb_valid_done", wb_valid, 0);
  endtask

  initial begin
    int k;
    logic [1:0] sz;
    logic [63:0] a;
    #1 check_reset("rst0");
    @(negedge clk) reset_n = 1;
    @(negedge clk);
    // LB signed from the top byte
    op(1, 0, 2'b00, 0, 64'h0000_1000_0000_0007, 64'h0, 64'h80AB_CDEF_0123_4567, 5'd1, 0, 0, 1);
    // SW at offset 4
    op(0, 1, 2'b10, 0, 64'h0000_2000_0000_0004, 64'h0000_0000_DEAD_BEEF, 64'h0, 5'd2, 0, 0, 0);
    // LD misaligned: straight to RESP
    op(1, 0, 2'b11, 0, 64'h0000_3000_0000_0003, 64'h0, 64'h1111_2222_3333_4444, 5'd3, 0, 0, 0);
    // cache_ready held low 5 cycles in REQ
    op(1, 0, 2'b10, 0, 64'h0000_4000_0000_0004, 64'h0, 64'h8765_4321_0000_0000, 5'd4, 5, 0, 2);
    // wb_ready held low 3 cycles in RESP, pass-through
    op(0, 0, 2'b00, 0, 64'h0, 64'hCAFE_F00D_1234_5678, 64'h0, 5'd5, 0, 3, 0);
    // stray cache_out_valid while idle must be ignored
    cache_out_valid = 1; cache_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    cache_out_valid = 0;
    chk("stray_ex_ready", ex_ready, 1);
    chk("stray_wb_valid", wb_valid, 0);
    // reset while in WAIT
    ex_valid = 1; ex_is_load = 1; ex_is_store = 0; ex_size = 2'b11; ex_addr = 64'h100; ex_rd = 5'd9;
    @(negedge clk);
    ex_valid = 0; cache_ready = 1;
    @(negedge clk);
    cache_ready = 0;
    chk("pre_rst_wait", cache_valid, 0);
    #2 reset_n = 0;
    #1 check_reset("rst_wait");
    @(negedge clk) reset_n = 1;
    @(negedge clk);
    op(1, 0, 2'b01, 1, 64'h2, 64'h0, 64'h1234_5678_ABCD_0000, 5'd6, 0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(2);
      sz = 2'($urandom);
      a = {$urandom, $urandom};
      if ($urandom_range(3) != 0) a = a & ~((64'd1 << sz) - 1);
      op(k == 0, k == 1, sz, 1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
         5'($urandom), $urandom_range(3), $urandom_range(2), $urandom_range(3));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
